fpu_addsub_seq: RTL and testbench

Multicycle IEEE-754-style floating-point adder/subtractor for the FPU datapath. It is parametrised in exponent and fraction width, and handles sign, magnitude subtraction, round-to-nearest-even, special operands and exception flags. It sits beside the ALU in the multicycle ARM datapath. The controller pulses start and waits for done, the same way it waits on other multicycle units.

---
 rtl/fpu_addsub_seq_if.sv | 19 +
 rtl/fpu_addsub_seq.sv | 171 +++++++++++++++++
 tb/tb_fpu_addsub_seq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fpu_addsub_seq_if.sv
// Handshake and operand/result bundle between the multicycle controller and the FP add/sub unit.
interface fpu_addsub_seq_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
);
  localparam int W = 1 + EXP_W + FRAC_W;

  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [3:0]   flags;

  modport master (output start, op, a, b, input busy, done, result, flags);
  modport slave  (input start, op, a, b, output busy, done, result, flags);
endinterface

// File: rtl/fpu_addsub_seq.sv
// Multicycle IEEE-754-style add/sub: ALIGN -> ADD -> NORM (1 shift/cycle) -> ROUND, RNE, no denormals.
module fpu_addsub_seq #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic             clk,
  input  logic             reset,
  fpu_addsub_seq_if.slave  bus
);
  localparam int W  = 1 + EXP_W + FRAC_W;
  localparam int MW = FRAC_W + 5;  // carry, hidden, fraction, G, R, S
  localparam logic [EXP_W-1:0] EMAX   = '1;
  localparam logic [EXP_W-1:0] SH_MAX = EXP_W'(FRAC_W + 3);
  localparam logic [EXP_W-1:0] EONE   = EXP_W'(1);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state, state_n;

  logic [W-1:0]     a_r, b_r, result_r;
  logic [3:0]       flags_r;
  logic             sgn, sub;
  logic [EXP_W-1:0] exp_r;
  logic [MW-1:0]    mx, my, m;

  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  assign {sa, ea, fa} = a_r;
  assign {sb, eb, fb} = b_r;

  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic is_nan, is_inf, both_zero, special;
  assign a_zero    = (ea == '0);
  assign b_zero    = (eb == '0);
  assign a_inf     = (ea == EMAX) && (fa == '0);
  assign b_inf     = (eb == EMAX) && (fb == '0);
  assign a_nan     = (ea == EMAX) && (fa != '0);
  assign b_nan     = (eb == EMAX) && (fb != '0);
  assign is_nan    = a_nan | b_nan | (a_inf & b_inf & (sa ^ sb));
  assign is_inf    = a_inf | b_inf;
  assign both_zero = a_zero & b_zero;
  assign special   = is_nan | is_inf | a_zero | b_zero;

  // exponent-then-fraction ordering is just an unsigned compare of the magnitude bits
  logic              a_big;
  logic [EXP_W-1:0]  e_big, e_sml, shamt;
  logic [FRAC_W-1:0] f_big, f_sml;
  logic [MW-1:0]     m_sml, al_sml;
  logic [2*MW-1:0]   sh;
  assign a_big  = (a_r[W-2:0] >= b_r[W-2:0]);
  assign e_big  = a_big ? ea : eb;
  assign e_sml  = a_big ? eb : ea;
  assign f_big  = a_big ? fa : fb;
  assign f_sml  = a_big ? fb : fa;
  assign shamt  = e_big - e_sml;
  assign m_sml  = {2'b01, f_sml, 3'b000};
  assign sh     = {m_sml, {MW{1'b0}}} >> shamt;
  assign al_sml = (shamt >= SH_MAX) ? MW'(1)
                                    : (sh[2*MW-1:MW] | MW'(|sh[MW-1:0]));

  logic [MW-1:0] sum;
  assign sum = sub ? (mx - my) : (mx + my);

  // hidden bit is always set on entry to ROUND, so a carry out means the fraction was all ones
  logic              inc, rcarry;
  logic [FRAC_W-1:0] rfrac;
  logic [EXP_W-1:0]  exp_inc;
  assign inc     = m[2] & (m[1] | m[0] | m[3]);
  assign rfrac   = m[MW-3:3] + FRAC_W'(inc);
  assign rcarry  = (&m[MW-3:3]) & inc;
  assign exp_inc = exp_r + EONE;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (bus.start) state_n = ALIGN;
      ALIGN: state_n = special ? DONE : ADD;
      ADD:   state_n = (sub && sum == '0) ? DONE : NORM;
      NORM: begin
        if (m[MW-1])       state_n = ROUND;
        else if (!m[MW-2]) state_n = (exp_r > EONE) ? NORM : DONE;
        else               state_n = ROUND;
      end
      ROUND: state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      result_r <= '0;
      flags_r  <= '0;
      a_r      <= '0;
      b_r      <= '0;
      sgn      <= 1'b0;
      sub      <= 1'b0;
      exp_r    <= '0;
      mx       <= '0;
      my       <= '0;
      m        <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (bus.start) begin
          a_r <= bus.a;
          b_r <= {bus.b[W-1] ^ bus.op, bus.b[W-2:0]};
        end
        ALIGN: begin
          if (is_nan) begin
            result_r <= {1'b0, EMAX, 1'b1, {(FRAC_W-1){1'b0}}};
            flags_r  <= 4'b1000;
          end else if (is_inf) begin
            result_r <= a_inf ? a_r : b_r;
            flags_r  <= 4'b0000;
          end else if (both_zero) begin
            result_r <= {sa & sb, {(W-1){1'b0}}};
            flags_r  <= 4'b0001;
          end else if (a_zero || b_zero) begin
            result_r <= a_zero ? b_r : a_r;
            flags_r  <= 4'b0000;
          end else begin
            sgn   <= a_big ? sa : sb;
            sub   <= sa ^ sb;
            exp_r <= e_big;
            mx    <= {2'b01, f_big, 3'b000};
            my    <= al_sml;
          end
        end
        ADD: begin
          if (sub && sum == '0) begin
            result_r <= '0;
            flags_r  <= 4'b0001;
          end else begin
            m <= sum;
          end
        end
        NORM: begin
          if (m[MW-1]) begin
            m     <= {1'b0, m[MW-1:2], m[1] | m[0]};
            exp_r <= exp_inc;
          end else if (!m[MW-2]) begin
            if (exp_r > EONE) begin
              m     <= m << 1;
              exp_r <= exp_r - EONE;
            end else begin
              result_r <= {sgn, {(W-1){1'b0}}};
              flags_r  <= 4'b0011;
            end
          end
        end
        ROUND: begin
          if (exp_r == EMAX || (rcarry && exp_inc == EMAX)) begin
            result_r <= {sgn, EMAX, {FRAC_W{1'b0}}};
            flags_r  <= 4'b0100;
          end else begin
            result_r <= {sgn, rcarry ? exp_inc : exp_r, rfrac};
            flags_r  <= 4'b0000;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);
  assign bus.result = result_r;
  assign bus.flags  = flags_r;
endmodule

// File: tb/tb_fpu_addsub_seq.sv
// Directed bench for fpu_addsub_seq: hand-computed single-precision vectors, latency and control checks.
module tb_fpu_addsub_seq;
  logic clk = 1'b0;
  logic reset;
  int   ncmp = 0;
  int   nfail = 0;

  fpu_addsub_seq_if #(.EXP_W(8), .FRAC_W(23)) bus ();
  fpu_addsub_seq #(.EXP_W(8), .FRAC_W(23)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one operation and check result, flags, latency and the busy/done shape around it.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic op, input logic [31:0] er, input logic [3:0] ef, input int el);
    int lat;
    @(negedge clk);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.op = op;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b; bus.op = ~op;
    lat = 1;
    chk({tag, "_busy1"}, 32'(bus.busy), 32'd1);
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_res"}, bus.result, er);
    chk({tag, "_flg"}, 32'(bus.flags), 32'(ef));
    chk({tag, "_busydone"}, 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
  endtask

  initial begin
    int seen;
    int lat;
    reset = 1'b1; bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.busy),  32'd0);
    chk("rst_done",   32'(bus.done),  32'd0);
    chk("rst_result", bus.result,     32'd0);
    chk("rst_flags",  32'(bus.flags), 32'd0);
    @(negedge clk); reset = 1'b0;

    run_op("add11",     32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 5);
    run_op("sub15_1",   32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 4'b0000, 6);
    run_op("cancel",    32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0001, 3);
    run_op("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0000, 5);
    run_op("above_hf",  32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0000, 5);
    run_op("tie_odd",   32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0000, 5);
    run_op("below_hf",  32'h3F800000, 32'h33000000, 1'b0, 32'h3F800000, 4'b0000, 5);
    run_op("ovf",       32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0100, 5);
    run_op("inf_m_inf", 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 2);
    run_op("ninf_p1",   32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000, 2);
    run_op("unf",       32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 4);
    run_op("shift24",   32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000, 4'b0000, 5);
    run_op("zero_m1",   32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 4'b0000, 2);
    run_op("nz_nz",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0001, 2);
    run_op("3_m1",      32'h40400000, 32'hBF800000, 1'b0, 32'h40000000, 4'b0000, 5);
    run_op("far_add",   32'h3F800000, 32'h0C800000, 1'b0, 32'h3F800000, 4'b0000, 5);
    run_op("far_sub",   32'h3F800000, 32'h0C800000, 1'b1, 32'h3F800000, 4'b0000, 6);

    // start pulsed mid-operation must not launch a second operation
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h3F800000; bus.op = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.a = 32'h40800000; bus.b = 32'h40800000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 3;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("ign_lat", lat, 5);
    chk("ign_res", bus.result, 32'h40000000);
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1;
    end
    chk("ign_noop", seen, 0);
    chk("ign_hold", bus.result, 32'h40000000);

    // reset while in NORM aborts with no done pulse
    @(negedge clk);
    bus.start = 1'b1; bus.a = 32'h3FC00000; bus.b = 32'h3F800000; bus.op = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy",   32'(bus.busy),  32'd0);
    chk("abort_done",   32'(bus.done),  32'd0);
    chk("abort_result", bus.result,     32'd0);
    chk("abort_flags",  32'(bus.flags), 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen = 1;
    end
    chk("abort_nodone", seen, 0);

    // run_op leaves us in the IDLE cycle right after done, so these two are back-to-back
    run_op("b2b_a", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 5);
    run_op("b2b_b", 32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
